// File: rtl/enable_pulse_gen.sv
// rtl/enable_pulse_gen.sv - one-cycle enable pulse source for the T-flip-flop counter
//
// Purpose: issues a registered one-cycle enable pulse either from a selectable
// rate divider (every cycle, 1 Hz, 0.5 Hz) or from a debounced manual step
// pushbutton, plus a heartbeat output that toggles on every issued pulse.
//
// Ports:
//   clk      - system clock, all state updates on its rising edge
//   clear_b  - synchronous active-low reset
//   run      - global enable; 0 suppresses pulses and freezes the divider
//   rate_sel - 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 manual step
//   step_n   - raw active-low pushbutton (asynchronous, bouncy)
//   pulse    - registered one-cycle enable to the downstream counter
//   beat     - registered, toggles on every issued pulse
module enable_pulse_gen #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 28,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       run,
  input  logic [1:0] rate_sel,
  input  logic       step_n,
  output logic       pulse,
  output logic       beat
);

  localparam logic [1:0] SEL_STEP = 2'b11;

  // Reload value for the divider: period minus one. Manual mode does not
  // use the divider, so it shares the every-cycle value.
  function automatic logic [CNT_W-1:0] period_m1(input logic [1:0] sel);
    case (sel)
      2'b01:   return CNT_W'(CLK_HZ - 1);
      2'b10:   return CNT_W'(2 * CLK_HZ - 1);
      default: return '0;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prev_sel_q, prev_sel_d;
  logic             pulse_q, pulse_d;
  logic             beat_q, beat_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    prev_sel_d = rate_sel;
    pulse_d    = 1'b0;
    s1_d       = step_n;
    s2_d       = s1_q;
    db_d       = db_q;
    db_prev_d  = db_q;
    deb_cnt_d  = deb_cnt_q;

    // Debouncer: a level change is accepted only after the synchronized
    // input has disagreed with db for DEB_CYCLES consecutive cycles; any
    // return to db before that restarts the count.
    if (s2_q == db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
      db_d      = s2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    if (rate_sel == SEL_STEP) begin
      // Falling edge of the debounced level is an accepted press; one
      // pulse per press, dropped (not queued) while run is low.
      pulse_d = run & db_prev_q & ~db_q;
    end else if (rate_sel != prev_sel_q) begin
      // Mode change restarts the period without issuing a pulse.
      cnt_d = period_m1(rate_sel);
    end else if (run) begin
      if (cnt_q == '0) begin
        pulse_d = 1'b1;
        cnt_d   = period_m1(rate_sel);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    beat_d = beat_q ^ pulse_d;
  end

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      cnt_q      <= period_m1(rate_sel);
      prev_sel_q <= rate_sel;
      pulse_q    <= 1'b0;
      beat_q     <= 1'b0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      db_q       <= 1'b1;
      db_prev_q  <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prev_sel_q <= prev_sel_d;
      pulse_q    <= pulse_d;
      beat_q     <= beat_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign pulse = pulse_q;
  assign beat  = beat_q;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb/tb_enable_pulse_gen.sv - directed-vector bench for enable_pulse_gen
module tb_enable_pulse_gen;

  logic       clk;
  logic       clear_b;
  logic       run;
  logic [1:0] rate_sel;
  logic       step_n;
  logic       pulse;
  logic       beat;

  int n_vec;
  int n_bad;

  enable_pulse_gen #(
    .CLK_HZ    (4),
    .DEB_CYCLES(3),
    .CNT_W     (8),
    .DEB_W     (4)
  ) dut (
    .clk     (clk),
    .clear_b (clear_b),
    .run     (run),
    .rate_sel(rate_sel),
    .step_n  (step_n),
    .pulse   (pulse),
    .beat    (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] sel, input logic r);
    clear_b  = 1'b0;
    rate_sel = sel;
    run      = r;
    step_n   = 1'b1;
    tick();
    chk("reset_pulse", pulse, 1'b0);
    chk("reset_beat", beat, 1'b0);
    clear_b = 1'b1;
  endtask

  // Runs n edges and expects no pulse on any of them.
  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, pulse, 1'b0);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    clear_b  = 1'b0;
    run      = 1'b0;
    rate_sel = 2'b00;
    step_n   = 1'b1;
    tick();

    // 1: every-cycle mode
    do_reset(2'b00, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("m00_pulse", pulse, 1'b1);
      chk("m00_beat", beat, logic'(e % 2));
    end
    run = 1'b0;
    tick();
    chk("m00_run_drop", pulse, 1'b0);
    chk("m00_beat_hold", beat, 1'b0);

    // 2: 1 Hz mode, run low on edges 14 and 15
    do_reset(2'b01, 1'b1);
    for (int e = 1; e <= 18; e++) begin
      run = !(e == 14 || e == 15);
      tick();
      chk("m01_pulse", pulse, (e == 4 || e == 8 || e == 12 || e == 18));
    end

    // 3: 0.5 Hz mode, switch to 1 Hz sampled at edge 19
    do_reset(2'b10, 1'b1);
    for (int e = 1; e <= 24; e++) begin
      if (e == 19) rate_sel = 2'b01;
      tick();
      chk("m10_pulse", pulse, (e == 8 || e == 16 || e == 23));
    end

    // 4: manual step press, latency 6 edges from first low sample
    do_reset(2'b11, 1'b1);
    expect_quiet("m11_idle", 2);
    step_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("m11_press", pulse, (e == 6));
    end
    chk("m11_beat", beat, 1'b1);
    step_n = 1'b1;
    expect_quiet("m11_release", 10);
    for (int g = 0; g < 4; g++) begin
      step_n = logic'(g % 2);
      tick();
      chk("m11_glitch", pulse, 1'b0);
    end
    step_n = 1'b1;
    expect_quiet("m11_glitch_tail", 8);
    chk("m11_beat_hold", beat, 1'b1);

    // 5: reset mid-period in 1 Hz mode
    do_reset(2'b01, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("rst_pre", pulse, (e == 4));
    end
    chk("rst_pre_beat", beat, 1'b1);
    clear_b = 1'b0;
    tick();
    chk("rst_mid_pulse", pulse, 1'b0);
    chk("rst_mid_beat", beat, 1'b0);
    clear_b = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("rst_post", pulse, (e == 4));
    end

    // 6: press while run=0 is discarded; debounced presses ignored in mode 00
    do_reset(2'b11, 1'b0);
    step_n = 1'b0;
    expect_quiet("m11_norun", 10);
    run = 1'b1;
    expect_quiet("m11_late_run", 8);
    step_n = 1'b1;
    expect_quiet("m11_late_rel", 8);
    chk("m11_norun_beat", beat, 1'b0);

    do_reset(2'b00, 1'b0);
    step_n = 1'b0;
    expect_quiet("m00_norun_press", 10);
    step_n = 1'b1;
    expect_quiet("m00_norun_rel", 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/enable_pulse_gen.md
Name: enable_pulse_gen

Overview:
Upstream stage for the 8-bit T-flip-flop counter/hex display block. It produces the one-cycle enable pulse that drives the counter's enable/T input. Pulses come either from a selectable rate divider off the 50 MHz board clock, or from a debounced manual step pushbutton. A toggle output gives a visible heartbeat on an LED.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz; the 1 Hz period equals CLK_HZ cycles.
DEB_CYCLES, 1000000, number of consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
CNT_W, 28, divider counter width; must hold 2*CLK_HZ-1.
DEB_W, 20, debounce counter width; must hold DEB_CYCLES-1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
clear_b  input  1  synchronous active-low reset; sampled on the rising edge of clk.
run  input  1  global enable; 0 suppresses all pulses and freezes the divider.
rate_sel  input  2  mode select: 00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = manual step.
step_n  input  1  raw active-low pushbutton; asynchronous and bouncy.
pulse  output  1  registered one-cycle enable to the downstream counter.
beat  output  1  registered; toggles on every issued pulse.

Behaviour:
- Reset (clear_b=0 at an edge) overrides everything, including mid-period and mid-debounce:
  - pulse=0, beat=0.
  - Divider count cnt = P(rate_sel)-1.
  - Synchronizer flops = 1; debounced state db=1 (released); db_prev=1; debounce counter = 0.
  - prev_sel = rate_sel.
- Period P: 00 → 1, 01 → CLK_HZ, 10 → 2*CLK_HZ. Mode 11 does not use the divider.
- Divider (rate_sel in 00/01/10), at each edge:
  - If rate_sel != prev_sel: cnt <= P(new)-1 and pulse <= 0. The period restarts and no pulse is issued on that edge.
  - Else if run=0: cnt holds and pulse <= 0.
  - Else if cnt==0: pulse <= 1 and cnt <= P-1.
  - Else: cnt <= cnt-1 and pulse <= 0.
  - Consequences:
    - Mode 00 gives pulse=1 on every edge while run=1.
    - Mode 01 gives the first pulse on the P-th run=1 edge after reset or reload, then every P run edges.
  - prev_sel <= rate_sel on every edge.
- Synchronizer: two flops on step_n (s1, then s2); s2 is the synchronized level.
- Debouncer (runs in all modes):
  - If s2==db: debounce counter <= 0.
  - Else if counter == DEB_CYCLES-1: db <= s2 and counter <= 0.
  - Else: counter increments.
  - Any return of s2 to db before acceptance clears the counter, so bounce shorter than DEB_CYCLES is ignored.
- Step pulse:
  - db_prev <= db on every edge.
  - In mode 11, when db_prev=1 and db=0 (accepted press) and run=1: pulse <= 1. Otherwise pulse <= 0.
  - Exactly one pulse per press. Release produces no pulse. A press accepted while run=0 is discarded, not queued.
  - Latency: pulse is high after the (DEB_CYCLES+3)-th edge, counting the first edge that samples step_n=0 as edge 1.
  - In modes 00/01/10, debounced presses never add pulses.
- beat <= ~beat on every edge at which pulse is set to 1.
- pulse is never high on two edges for a single press. In modes 01/10 it is never high on consecutive edges.

Test Plan:
All scenarios use CLK_HZ=4, DEB_CYCLES=3.
1. Release clear_b with rate_sel=00 and run=1 → pulse=1 on every edge and beat alternates 1,0,1,…; drop run → pulse=0 on the next edge.
2. rate_sel=01, run=1 from reset → pulse high on edges 4, 8, 12 only. Then hold run=0 for 2 edges after edge 13 → next pulse at edge 18.
3. rate_sel=10 → pulses at edges 8 and 16. Switch to 01 at edge 19 → no pulse at 19; next pulse at edge 23.
4. rate_sel=11, run=1, step_n held low 10 cycles → a single pulse after edge 6 (counted from first low sample), beat=1. Glitch pattern 0,1,0,1 (1 cycle each) → no pulse. Release → no pulse.
5. clear_b=0 for one edge at edge 6 in mode 01 → pulse=0 and beat=0 immediately; next pulse 4 edges after release.
6. Mode 11 press with run=0 → no pulse, including after run is raised later. Mode 00 with run=0 plus a press → pulse stays 0.
